sram_bist_sequencer: RTL

- Upstream driver for the SRAM BIST/debug bus. It converts one parallel read or write request into the nibble-serial command stream (`rtap_srams_bist_command` / `rtap_srams_bist_data`) that is broadcast to every dp_ram/sp_ram wrapper.
- It collects the OR-combined `srams_rtap_data` return nibbles and rebuilds the 384-bit read response.
- It sits between the RTAP JTAG decoder and the SRAM wrappers. One transaction is in flight at a time.

---
 rtl/sram_bist_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_bist_sequencer.sv
// SRAM BIST bus sequencer: turns one parallel read/write request into the
// nibble-serial command/data stream broadcast to the SRAM wrappers, and
// rebuilds the 384-bit read response from the OR-combined return nibbles.
`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 3
`endif

module sram_bist_sequencer #(
    parameter int                   OP_WIDTH       = `BIST_OP_WIDTH,
    parameter int                   GUARD_CYCLES   = 2,
    parameter logic [OP_WIDTH-1:0]  CMD_NOP        = OP_WIDTH'(0),
    parameter logic [OP_WIDTH-1:0]  CMD_SHIFT_ID   = OP_WIDTH'(1),
    parameter logic [OP_WIDTH-1:0]  CMD_SHIFT_BSEL = OP_WIDTH'(2),
    parameter logic [OP_WIDTH-1:0]  CMD_SHIFT_ADDR = OP_WIDTH'(3),
    parameter logic [OP_WIDTH-1:0]  CMD_READ       = OP_WIDTH'(4),
    parameter logic [OP_WIDTH-1:0]  CMD_SHIFT_DATA = OP_WIDTH'(5)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [7:0]          req_sram_id_i,
    input  logic [7:0]          req_chunk_id_i,
    input  logic [15:0]         req_addr_i,
    input  logic [319:0]        req_wdata_i,
    output logic                rsp_valid_o,
    output logic                rsp_is_write_o,
    output logic [383:0]        rsp_rdata_o,
    output logic [OP_WIDTH-1:0] bist_command_o,
    output logic [3:0]          bist_data_o,
    input  logic [3:0]          bist_rsp_data_i
);

    typedef enum logic [3:0] {
        IDLE, HDR, RD_CMD, RD_WAIT, RD_SHIFT, WR_SHIFT, WR_COMMIT, RSP, GUARD
    } state_e;

    state_e                state_q, state_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  wr_q;
    logic [31:0]           hdr_q, hdr_d;
    logic [319:0]          wdata_q;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_is_write_q, rsp_is_write_d;
    logic [383:0]          rdata_q;
    logic [OP_WIDTH-1:0]   cmd_q, cmd_d;
    logic [3:0]            data_q, data_d;
    logic [4:0]            hdr_sh;
    logic [8:0]            wr_sh;

    wire accept = (state_q == IDLE) && req_valid_i;

    // Next state and counter; counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid_i) state_d = HDR;
            HDR:       if (cnt_q == 7'd7) state_d = wr_q ? WR_SHIFT : RD_CMD;
            RD_CMD:    state_d = RD_WAIT;
            RD_WAIT:   state_d = RD_SHIFT;
            RD_SHIFT:  if (cnt_q == 7'd95) state_d = RSP;
            WR_SHIFT:  if (cnt_q == 7'd79) state_d = WR_COMMIT;
            WR_COMMIT: if (cnt_q == 7'd1) state_d = RSP;
            RSP:       state_d = GUARD;
            GUARD:     if (cnt_q == 7'(GUARD_CYCLES - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_d == IDLE) ? 7'd0 : cnt_q + 7'd1;
    end

    // Outputs are computed from the next state so that the registered
    // command/data line up with the cycle the sequencer is entering.
    always_comb begin
        hdr_d          = accept ? {req_sram_id_i, req_chunk_id_i, req_addr_i} : hdr_q;
        hdr_sh         = {~cnt_d[2:0], 2'b00};
        wr_sh          = {7'd79 - cnt_d, 2'b00};
        cmd_d          = CMD_NOP;
        data_d         = 4'h0;
        req_ready_d    = (state_d == IDLE);
        rsp_valid_d    = (state_d == RSP);
        rsp_is_write_d = (state_d == RSP) ? wr_q : rsp_is_write_q;
        case (state_d)
            HDR: begin
                cmd_d  = (cnt_d < 7'd2) ? CMD_SHIFT_ID :
                         (cnt_d < 7'd4) ? CMD_SHIFT_BSEL : CMD_SHIFT_ADDR;
                data_d = hdr_d[hdr_sh +: 4];
            end
            RD_CMD:   cmd_d = CMD_READ;
            RD_SHIFT: cmd_d = CMD_SHIFT_DATA;
            WR_SHIFT: begin
                cmd_d  = CMD_SHIFT_DATA;
                data_d = wdata_q[wr_sh +: 4];
            end
            default: ;
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 7'd0;
            wr_q           <= 1'b0;
            hdr_q          <= 32'd0;
            wdata_q        <= 320'd0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rdata_q        <= 384'd0;
            cmd_q          <= CMD_NOP;
            data_q         <= 4'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hdr_q          <= hdr_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_write_q <= rsp_is_write_d;
            cmd_q          <= cmd_d;
            data_q         <= data_d;
            if (accept) begin
                wr_q    <= req_write_i;
                wdata_q <= req_wdata_i;
            end
            // Return nibbles arrive MSB-first; the first lands in [383:380].
            if (state_q == RD_SHIFT)
                rdata_q <= {rdata_q[379:0], bist_rsp_data_i};
        end
    end

    assign req_ready_o    = req_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_is_write_o = rsp_is_write_q;
    assign rsp_rdata_o    = rdata_q;
    assign bist_command_o = cmd_q;
    assign bist_data_o    = data_q;

endmodule
